scorbetta_goa: RTL and testbench
================================

# scorbetta_goa

Game-of-Life accelerator: an 8x8 toroidal Conway grid held in 64 flip-flops, loaded row-by-row, advanced one generation per clock (single-step or free-run), and read back row-by-row. Top-level user block of the tile; all I/O goes through the standard tile pin bundle.

## Interface
Parameters: none.
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  synchronous reset, active-high (asserted when 1, despite the name)
- ena  in  1  block enable; 0 freezes all state
- ui_in  in  8  row write data; bit i = column i
- uio_in  in  8  [2:0] row address, [3] write, [4] step, [5] run, [6] counter select, [7] unused
- uo_out  out  8  registered readout (row data or counter byte)
- uio_out  out  8  [7] empty flag, [6] stable flag, [5:0] = 0
- uio_oe  out  8  constant 8'hC0

## Operation
- Grid: row[0..7], 8 bits each; cell (r,c) = row[r][c]. Neighbours wrap modulo 8 in both axes.
- Rules: live cell with 2 or 3 live neighbours survives; dead cell with exactly 3 becomes live; all others dead. Next generation computed combinationally from the full current grid.
- Commands sampled each edge when ena=1, priority write > step > run:
  - write (uio_in[3]=1): row[addr] <= ui_in. No generation that cycle.
  - step: rising edge of uio_in[4] (registered previous value, reset 0) triggers exactly one generation.
  - run (uio_in[5]=1): one generation every cycle.
- Flags (registered): empty = 1 iff all 64 cells dead. stable set when a generation produces next == current; cleared by any write or any generation that changes the grid; unchanged otherwise.
- Readout: uo_out <= row[addr] each enabled edge (see Configuration for counter select).
- ena=0: grid, flags, counter, step history and uo_out hold.
- Reset: grid 0, uo_out 0x00, empty 1, stable 0, counter 0, step history 0.

## Timing
- Write or generation at edge k; grid updated at edge k; uo_out/empty reflect it after edge k+1 (readout latency 1 cycle from grid state).
- stable updated at edge k together with the grid.
- Step held high: exactly one generation; requires low for ≥1 sampled cycle before the next.
- Write with step/run active: write wins, step edge is consumed (not deferred).
- Reset has priority over ena and all commands; mid-run reset clears grid on that edge.

## Configuration
- GOA_GEN_COUNTER_EN defined: 16-bit generation counter, +1 per generation, wraps 0xFFFF->0x0000, cleared by reset and by any write. When uio_in[6]=1, uo_out <= counter[7:0] if addr[0]=0, else counter[15:8].
- Not defined: no counter; uio_in[6] ignored; uo_out always row data.

## Test plan
- Blinker: write row3=0x1C, others 0; one step -> rows 2,3,4 read 0x08, others 0x00; second step -> row3=0x1C again; stable=0 throughout.
- Wrap: write row0=0x83; step -> rows 7,0,1 read 0x01, others 0x00.
- Still life: rows 3,4 = 0x18; step -> unchanged, stable=1, empty=0.
- Death: row0=0x01 only; step -> all rows 0x00, empty=1, stable=0; next step -> stable=1.
- Run + reset: blinker, run=1 for 5 cycles -> row3 reads 0x08 (odd count); assert rst_n=1 mid-run -> next readout 0x00, empty=1; with ena=0 during run, grid unchanged.
- Counter (macro on): reset, 300 generations via run -> counter select, addr0 reads 0x2C, addr1 reads 0x01; a write then clears to 0x0000.

Source files
------------

// File: rtl/scorbetta_goa_if.sv
// Tile pin bundle for the Game-of-Life accelerator: enable, row data/command inputs,
// registered readout and flag outputs.
interface scorbetta_goa_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/scorbetta_goa.sv
// 8x8 toroidal Conway grid: row load, single-step/free-run generations, registered readout.
// Optional GOA_GEN_COUNTER_EN adds a 16-bit generation counter readable via uio_in[6].
module scorbetta_goa (
  input logic             clk,
  input logic             rst_n,
  scorbetta_goa_if.slave  bus
);

  logic [7:0][7:0] grid_q, grid_d, next_grid;
  logic [7:0]      uo_q, uo_d;
  logic            empty_q, empty_d;
  logic            stable_q, stable_d;
  logic            step_prev_q, step_prev_d;
  logic [3:0]      nbr;
  logic [2:0]      addr;
  logic            wr, step, run, sel, gen;
`ifdef GOA_GEN_COUNTER_EN
  logic [15:0]     cnt_q, cnt_d;
`endif

  logic unused_in;
  assign unused_in = ^{bus.uio_in[7], sel};

  assign addr = bus.uio_in[2:0];
  assign wr   = bus.uio_in[3];
  assign step = bus.uio_in[4];
  assign run  = bus.uio_in[5];
  assign sel  = bus.uio_in[6];
  // A write swallows a coincident step edge; step_prev still tracks the input.
  assign gen  = !wr && ((step && !step_prev_q) || run);

  // Neighbour offsets 7..9 are -1..+1 modulo 8; the 3-bit cast gives the torus wrap.
  always_comb begin
    next_grid = '0;
    nbr       = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        nbr = '0;
        for (int dr = 7; dr <= 9; dr++) begin
          for (int dc = 7; dc <= 9; dc++) begin
            if (dr != 8 || dc != 8) begin
              nbr = nbr + {3'b000, grid_q[3'(r + dr)][3'(c + dc)]};
            end
          end
        end
        next_grid[r][c] = (nbr == 4'd3) || (grid_q[r][c] && (nbr == 4'd2));
      end
    end
  end

  always_comb begin
    grid_d      = grid_q;
    uo_d        = uo_q;
    empty_d     = empty_q;
    stable_d    = stable_q;
    step_prev_d = step_prev_q;
`ifdef GOA_GEN_COUNTER_EN
    cnt_d       = cnt_q;
`endif
    if (bus.ena) begin
      step_prev_d = step;
      empty_d     = (grid_q == '0);
      uo_d        = grid_q[addr];
`ifdef GOA_GEN_COUNTER_EN
      if (sel) uo_d = addr[0] ? cnt_q[15:8] : cnt_q[7:0];
`endif
      if (wr) begin
        grid_d[addr] = bus.ui_in;
        stable_d     = 1'b0;
`ifdef GOA_GEN_COUNTER_EN
        cnt_d        = '0;
`endif
      end else if (gen) begin
        grid_d   = next_grid;
        stable_d = (next_grid == grid_q);
`ifdef GOA_GEN_COUNTER_EN
        cnt_d    = cnt_q + 16'd1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      grid_q      <= '0;
      uo_q        <= '0;
      empty_q     <= 1'b1;
      stable_q    <= 1'b0;
      step_prev_q <= 1'b0;
`ifdef GOA_GEN_COUNTER_EN
      cnt_q       <= '0;
`endif
    end else begin
      grid_q      <= grid_d;
      uo_q        <= uo_d;
      empty_q     <= empty_d;
      stable_q    <= stable_d;
      step_prev_q <= step_prev_d;
`ifdef GOA_GEN_COUNTER_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = {empty_q, stable_q, 6'b000000};
  assign bus.uio_oe  = 8'hC0;

endmodule

// File: tb/tb_scorbetta_goa.sv
// Directed-vector bench for scorbetta_goa: known Life patterns with hand-computed rows,
// flags and (when GOA_GEN_COUNTER_EN is defined) counter bytes.
module tb_scorbetta_goa;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] rd;

  scorbetta_goa_if bus ();

  scorbetta_goa u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change only at the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b1;
    bus.uio_in = 8'h00;
    tick();
    rst_n = 1'b0;
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] d);
    bus.ui_in  = d;
    bus.uio_in = {5'b00001, r};
    tick();
    bus.uio_in = 8'h00;
  endtask

  task automatic step_once();
    bus.uio_in = 8'h10;
    tick();
    bus.uio_in = 8'h00;
    tick();
  endtask

  task automatic read_row(input logic [2:0] r, output logic [7:0] d);
    bus.uio_in = {5'b00000, r};
    tick();
    d = bus.uo_out;
  endtask

  task automatic expect_rows(input string tag, input logic [7:0] exp [8]);
    logic [7:0] v;
    for (int r = 0; r < 8; r++) begin
      read_row(3'(r), v);
      check_eq($sformatf("%s_row%0d", tag, r), {8'h00, v}, {8'h00, exp[r]});
    end
  endtask

  logic [7:0] exp_vert [8]  = '{8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_horiz [8] = '{8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_wrap [8]  = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  logic [7:0] exp_block [8] = '{8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_zero [8]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b1;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    @(negedge clk);
    do_reset();

    check_eq("reset_uo", {8'h00, bus.uo_out}, 16'h0000);
    check_eq("reset_flags", {8'h00, bus.uio_out}, 16'h0080);
    check_eq("reset_oe", {8'h00, bus.uio_oe}, 16'h00C0);

    // Blinker oscillates horizontal <-> vertical, never stable.
    write_row(3'd3, 8'h1C);
    step_once();
    expect_rows("blink1", exp_vert);
    check_eq("blink1_stable", {15'd0, bus.uio_out[6]}, 16'd0);
    step_once();
    expect_rows("blink2", exp_horiz);
    check_eq("blink2_stable", {15'd0, bus.uio_out[6]}, 16'd0);
    check_eq("blink2_empty", {15'd0, bus.uio_out[7]}, 16'd0);

    // Holding step high yields exactly one generation.
    bus.uio_in = 8'h10;
    repeat (4) tick();
    bus.uio_in = 8'h00;
    tick();
    read_row(3'd3, rd);
    check_eq("step_held", {8'h00, rd}, 16'h0008);

    // Write coinciding with a step edge wins and consumes the edge.
    do_reset();
    bus.ui_in  = 8'h1C;
    bus.uio_in = 8'h1B;
    tick();
    bus.uio_in = 8'h03;
    tick();
    read_row(3'd3, rd);
    check_eq("write_beats_step", {8'h00, rd}, 16'h001C);

    // Vertical blinker across the row-7/row-0/row-1 seam and column-7/column-0 seam.
    do_reset();
    write_row(3'd0, 8'h83);
    step_once();
    expect_rows("wrap", exp_wrap);

    // Block still life.
    do_reset();
    write_row(3'd3, 8'h18);
    write_row(3'd4, 8'h18);
    step_once();
    expect_rows("block", exp_block);
    check_eq("block_stable", {15'd0, bus.uio_out[6]}, 16'd1);
    check_eq("block_empty", {15'd0, bus.uio_out[7]}, 16'd0);

    // Lone cell dies; the following generation is a no-op, hence stable.
    do_reset();
    write_row(3'd0, 8'h01);
    step_once();
    expect_rows("death", exp_zero);
    check_eq("death_empty", {15'd0, bus.uio_out[7]}, 16'd1);
    check_eq("death_stable", {15'd0, bus.uio_out[6]}, 16'd0);
    step_once();
    check_eq("death_stable2", {15'd0, bus.uio_out[6]}, 16'd1);
    write_row(3'd5, 8'h00);
    check_eq("write_clears_stable", {15'd0, bus.uio_out[6]}, 16'd0);

    // Free-run: five generations leave the blinker vertical.
    do_reset();
    write_row(3'd3, 8'h1C);
    bus.uio_in = 8'h23;
    repeat (5) tick();
    read_row(3'd3, rd);
    check_eq("run5_row3", {8'h00, rd}, 16'h0008);

    // Enable low freezes the grid despite run.
    bus.ena    = 1'b0;
    bus.uio_in = 8'h23;
    repeat (3) tick();
    check_eq("ena0_uo_hold", {8'h00, bus.uo_out}, 16'h0008);
    bus.ena = 1'b1;
    read_row(3'd3, rd);
    check_eq("ena0_row3", {8'h00, rd}, 16'h0008);
    read_row(3'd2, rd);
    check_eq("ena0_row2", {8'h00, rd}, 16'h0008);

    // Reset mid-run wins over run and enable.
    bus.uio_in = 8'h23;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check_eq("rst_mid_uo", {8'h00, bus.uo_out}, 16'h0000);
    read_row(3'd3, rd);
    check_eq("rst_mid_row3", {8'h00, rd}, 16'h0000);
    check_eq("rst_mid_empty", {15'd0, bus.uio_out[7]}, 16'd1);

    // 300 generations = 0x012C.
    do_reset();
    bus.uio_in = 8'h20;
    repeat (300) tick();
`ifdef GOA_GEN_COUNTER_EN
    bus.uio_in = 8'h40;
    tick();
    check_eq("cnt_lo", {8'h00, bus.uo_out}, 16'h002C);
    bus.uio_in = 8'h41;
    tick();
    check_eq("cnt_hi", {8'h00, bus.uo_out}, 16'h0001);
    write_row(3'd0, 8'h00);
    bus.uio_in = 8'h40;
    tick();
    check_eq("cnt_clr_lo", {8'h00, bus.uo_out}, 16'h0000);
    bus.uio_in = 8'h41;
    tick();
    check_eq("cnt_clr_hi", {8'h00, bus.uo_out}, 16'h0000);
`else
    write_row(3'd0, 8'hA5);
    bus.uio_in = 8'h40;
    tick();
    check_eq("sel_ignored", {8'h00, bus.uo_out}, 16'h00A5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
